// File: rtl/bp_pkg.sv
// bp_pkg: shared types, mode constants and index hash for the branch predictors.
package bp_pkg;
  typedef enum logic {INIT, RUN} bp_state_t;
  localparam int BP_MODE_BIMODAL = 0;
  localparam int BP_MODE_GSHARE = 1;
  // Callers zero-extend their fields to 32 bits and truncate the result to their index width.
  function automatic logic [31:0] bp_index(input logic [31:0] pc_bits, input logic [31:0] hist,
                                           input logic gshare);
    return pc_bits ^ (gshare ? hist : 32'd0);
  endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next value of an up/down counter that saturates at both ends.
module bp_sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] cur,
  input  logic             inc,
  output logic [CTR_W-1:0] nxt
);
  always_comb nxt = inc ? (&cur ? cur : cur + 1'b1) : (|cur ? cur - 1'b1 : cur);
endmodule

// File: rtl/gshare_history_table.sv
// gshare_history_table: saturating-counter direction predictor with global history,
// cleared by a sweep after reset and trained from execute.
module gshare_history_table import bp_pkg::*; #(
  parameter int ADDR_W      = 7,
  parameter int ENTRIES     = 32,
  parameter int INDEX_SHIFT = 2,
  parameter int CTR_W       = 2,
  parameter int INIT_CTR    = 1,
  parameter int GHR_W       = 5,
  parameter int MODE        = BP_MODE_GSHARE
) (
  input  logic              clk,
  input  logic              arst_n,
  output logic              ready,
  input  logic              lookup_en,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              pred_valid,
  output logic              prediction,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic [GHR_W-1:0]  upd_ghr
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic GSHARE = (MODE == BP_MODE_GSHARE);
  bp_state_t state, state_nxt;
  logic [IDX_W-1:0] ptr, lk_idx, up_idx;
  logic [GHR_W-1:0] ghr;
  logic [CTR_W-1:0] tbl [ENTRIES];
  logic [CTR_W-1:0] ctr_nxt;
  logic run, lu, pred_bit;
  logic unused_bits;
  assign run = state == RUN;
  assign ready = run;
  assign lu = run & lookup_en;
  assign lk_idx = IDX_W'(bp_index(32'(lookup_addr[INDEX_SHIFT +: IDX_W]), 32'(ghr), GSHARE));
  assign up_idx = IDX_W'(bp_index(32'(upd_addr[INDEX_SHIFT +: IDX_W]), 32'(upd_ghr), GSHARE));
  assign pred_bit = tbl[lk_idx][CTR_W-1];
  assign unused_bits = ^{lookup_addr, upd_addr, upd_ghr};
  bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (.cur(tbl[up_idx]), .inc(upd_taken), .nxt(ctr_nxt));
  always_comb state_nxt = (state == INIT && ptr == IDX_W'(ENTRIES - 1)) ? RUN : state;
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state      <= INIT;
      ptr        <= '0;
      ghr        <= '0;
      pred_valid <= 1'b0;
      prediction <= 1'b0;
      pred_ghr   <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= run ? ptr : ptr + 1'b1;
      pred_valid <= lu;
      if (lu) begin
        prediction <= pred_bit;
        pred_ghr   <= ghr;
      end
      // Truncating {history, bit} keeps the newest GHR_W bits, also for GHR_W = 1.
      ghr <= (run && upd_en && upd_mispredict) ? GHR_W'({upd_ghr, upd_taken}) :
             lu ? GHR_W'({ghr, pred_bit}) : ghr;
    end
  end
  // Single write port: the clear sweep owns it in INIT, training owns it in RUN.
  always_ff @(posedge clk) begin
    if (arst_n) begin
      if (!run) tbl[ptr] <= CTR_W'(INIT_CTR);
      else if (upd_en) tbl[up_idx] <= ctr_nxt;
    end
  end
endmodule

// File: tb/tb_gshare_history_table.sv
// tb_gshare_history_table: gshare and bimodal instances on shared stimulus, checked
// against an array-based reference model of the predictor's rules.
module tb_gshare_history_table;
  logic clk = 1'b0;
  logic arst_n, lookup_en, upd_en, upd_taken, upd_mispredict;
  logic [6:0] lookup_addr, upd_addr;
  logic [4:0] upd_ghr;
  logic rdy_g, pv_g, pr_g, rdy_b, pv_b, pr_b;
  logic [4:0] pg_g, pg_b;
  int checks = 0, failures = 0;
  int m_tbl [2][32];
  int m_ghr [2];
  int e_g [2];
  bit e_v [2], e_p [2];
  bit m_run;
  int m_cnt;

  always #5 clk = ~clk;

  gshare_history_table #(.MODE(1)) dut_g (
    .clk(clk), .arst_n(arst_n), .ready(rdy_g), .lookup_en(lookup_en), .lookup_addr(lookup_addr),
    .pred_valid(pv_g), .prediction(pr_g), .pred_ghr(pg_g), .upd_en(upd_en), .upd_addr(upd_addr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr));
  gshare_history_table #(.MODE(0)) dut_b (
    .clk(clk), .arst_n(arst_n), .ready(rdy_b), .lookup_en(lookup_en), .lookup_addr(lookup_addr),
    .pred_valid(pv_b), .prediction(pr_b), .pred_ghr(pg_b), .upd_en(upd_en), .upd_addr(upd_addr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr));

  // instance 0 is gshare, instance 1 bimodal
  function automatic int midx(int a, int h, int i);
    return ((a >> 2) & 31) ^ (i == 0 ? (h & 31) : 0);
  endfunction

  function automatic logic [13:0] expv();
    return {e_v[0], e_p[0], 5'(e_g[0]), e_v[1], e_p[1], 5'(e_g[1])};
  endfunction

  function automatic logic [13:0] obsv();
    return {pv_g, pr_g, pg_g, pv_b, pr_b, pg_b};
  endfunction

  task automatic idle();
    lookup_en = 0; upd_en = 0; upd_taken = 0; upd_mispredict = 0;
    lookup_addr = 0; upd_addr = 0; upd_ghr = 0;
  endtask

  task automatic junk();
    lookup_en = 1'($urandom); upd_en = 1'($urandom); upd_taken = 1'($urandom);
    upd_mispredict = 1'($urandom); lookup_addr = 7'($urandom); upd_addr = 7'($urandom);
    upd_ghr = 5'($urandom);
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUTs.
  task automatic cycle();
    bit pr;
    int li, ui, c;
    if (!arst_n) begin
      m_run = 0; m_cnt = 0;
      for (int i = 0; i < 2; i++) begin m_ghr[i] = 0; e_v[i] = 0; e_p[i] = 0; e_g[i] = 0; end
    end else if (!m_run) begin
      m_cnt++;
      for (int i = 0; i < 2; i++) e_v[i] = 0;
      if (m_cnt == 32) begin
        m_run = 1;
        for (int i = 0; i < 2; i++) for (int j = 0; j < 32; j++) m_tbl[i][j] = 1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        li = midx(int'(lookup_addr), m_ghr[i], i);
        pr = m_tbl[i][li] >= 2;
        e_v[i] = lookup_en;
        if (lookup_en) begin e_p[i] = pr; e_g[i] = m_ghr[i]; end
        if (upd_en) begin
          ui = midx(int'(upd_addr), int'(upd_ghr), i);
          c = m_tbl[i][ui];
          m_tbl[i][ui] = upd_taken ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
        end
        if (upd_en && upd_mispredict) m_ghr[i] = ((int'(upd_ghr) << 1) | int'(upd_taken)) & 31;
        else if (lookup_en) m_ghr[i] = ((m_ghr[i] << 1) | int'(pr)) & 31;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); arst_n = 0; cycle(); cycle(); arst_n = 1;
    repeat (32) cycle();
  endtask

  task automatic test_reset();
    idle(); arst_n = 0; cycle(); cycle(); arst_n = 1;
    for (int k = 0; k <= 32; k++) begin
      checks++;
      if ({rdy_g, rdy_b, pv_g, pv_b} !== (k >= 32 ? 4'b1100 : 4'b0000)) begin
        failures++;
        $display("FAIL reset_ready k=%0d got=%b want=%b", k, {rdy_g, rdy_b, pv_g, pv_b}, (k >= 32 ? 4'b1100 : 4'b0000));
      end
      if (k < 32) cycle();
    end
    for (int a = 0; a < 128; a += 4) begin
      lookup_en = 1; lookup_addr = 7'(a); cycle(); idle();
      checks++;
      if (obsv() !== expv() || {pr_g, pr_b} !== 2'b00) begin
        failures++;
        $display("FAIL reset_lookup addr=%0d got=%h want=%h", a, obsv(), expv());
      end
    end
  endtask

  task automatic test_saturation();
    bit tk [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    bit ep [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int s = 0; s < 11; s++) begin
      upd_en = 1; upd_addr = 7'h10; upd_taken = tk[s]; upd_ghr = 5'($urandom); cycle(); idle();
      lookup_en = 1; lookup_addr = 7'h10; cycle(); idle();
      checks++;
      if (pr_b !== ep[s] || obsv() !== expv()) begin
        failures++;
        $display("FAIL saturation step=%0d got=%h/%b want=%h/%b", s, obsv(), pr_b, expv(), ep[s]);
      end
    end
  endtask

  task automatic test_gshare_alias();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      lookup_en = 1; lookup_addr = 7'h20; cycle(); idle();
      checks++;
      if ({pv_g, pr_g, pg_g} !== 7'b1000000 || obsv() !== expv()) begin
        failures++;
        $display("FAIL alias_ghr0 n=%0d got=%h want=%h", n, obsv(), expv());
      end
    end
    repeat (2) begin upd_en = 1; upd_addr = 7'h20; upd_taken = 1; upd_ghr = 5'b00011; cycle(); end
    upd_mispredict = 1; upd_ghr = 5'b00001; cycle(); idle();
    lookup_en = 1; lookup_addr = 7'h20; cycle(); idle();
    checks++;
    if ({pr_g, pg_g} !== 6'b100011 || obsv() !== expv()) begin
      failures++;
      $display("FAIL alias_entry11 got=%h want=%h", obsv(), expv());
    end
    upd_en = 1; upd_mispredict = 1; upd_addr = 7'h20; upd_taken = 0; upd_ghr = 0; cycle(); idle();
    lookup_en = 1; lookup_addr = 7'h20; cycle(); idle();
    checks++;
    if ({pr_g, pg_g} !== 6'b000000 || obsv() !== expv()) begin
      failures++;
      $display("FAIL alias_entry8 got=%h want=%h", obsv(), expv());
    end
  endtask

  task automatic test_recovery();
    do_reset();
    upd_en = 1; upd_mispredict = 1; upd_addr = 7'h7c; upd_taken = 0; upd_ghr = 5'b01011; cycle();
    lookup_en = 1; lookup_addr = 0; upd_taken = 1; upd_ghr = 5'b01001; cycle(); idle();
    checks++;
    if ({pg_g, pg_b} !== {2{5'b10110}} || obsv() !== expv()) begin
      failures++;
      $display("FAIL recovery_setup got=%h want=%h", obsv(), expv());
    end
    lookup_en = 1; lookup_addr = 7'h04; cycle(); idle();
    checks++;
    if ({pg_g, pg_b} !== {2{5'b10011}} || obsv() !== expv()) begin
      failures++;
      $display("FAIL recovery_override got=%h want=%h", obsv(), expv());
    end
  endtask

  task automatic test_conflict();
    do_reset();
    lookup_en = 1; lookup_addr = 7'h40; upd_en = 1; upd_addr = 7'h40; upd_taken = 1; cycle(); idle();
    checks++;
    if ({pr_g, pr_b} !== 2'b00 || obsv() !== expv()) begin
      failures++;
      $display("FAIL conflict_old got=%h want=%h", obsv(), expv());
    end
    lookup_en = 1; lookup_addr = 7'h40; cycle(); idle();
    checks++;
    if ({pr_g, pr_b} !== 2'b11 || obsv() !== expv()) begin
      failures++;
      $display("FAIL conflict_new got=%h want=%h", obsv(), expv());
    end
  endtask

  task automatic test_reset_mid_sweep();
    idle(); arst_n = 0; cycle(); arst_n = 1;
    repeat (10) begin junk(); cycle(); end
    idle(); arst_n = 0; cycle(); arst_n = 1;
    for (int k = 0; k <= 32; k++) begin
      checks++;
      if ({rdy_g, rdy_b, pv_g, pv_b} !== (k >= 32 ? 4'b1100 : 4'b0000)) begin
        failures++;
        $display("FAIL sweep_restart k=%0d got=%b want=%b", k, {rdy_g, rdy_b, pv_g, pv_b}, (k >= 32 ? 4'b1100 : 4'b0000));
      end
      if (k < 32) begin junk(); cycle(); end
      idle();
    end
    for (int a = 0; a < 128; a += 4) begin
      lookup_en = 1; lookup_addr = 7'(a); cycle(); idle();
      checks++;
      if ({pr_g, pg_g, pr_b, pg_b} !== 12'd0 || obsv() !== expv()) begin
        failures++;
        $display("FAIL sweep_clean addr=%0d got=%h want=%h", a, obsv(), expv());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      junk();
      arst_n = ($urandom_range(0, 199) != 0);
      cycle();
      checks++;
      if (obsv() !== expv() || {rdy_g, rdy_b} !== {2{m_run}}) begin
        failures++;
        $display("FAIL random n=%0d got=%h/%b want=%h/%b", n, obsv(), rdy_g, expv(), m_run);
      end
    end
    arst_n = 1; idle();
  endtask

  initial begin
    idle(); arst_n = 0;
    test_reset();
    test_saturation();
    test_gshare_alias();
    test_recovery();
    test_conflict();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gshare_history_table.md
# gshare_history_table

Parametrised direction predictor for the fetch stage: a table of saturating counters, indexed by PC bits optionally XOR-ed with a global history register (GHR). The table produces a registered taken/not-taken prediction and is trained by the execute stage. It supports variable depth, counter width and history length, a bimodal/gshare mode, and a synchronous table-clear sweep after reset. GHR recovery on mispredict is supported.

## Interface
- ADDR_W, 7: width of lookup/update PC fields.
- ENTRIES, 32: table depth; power of two; IDX_W = log2(ENTRIES).
- INDEX_SHIFT, 2: PC bits dropped below the index (word-aligned PCs); ADDR_W ≥ INDEX_SHIFT + IDX_W.
- CTR_W, 2: counter width, ≥ 1.
- INIT_CTR, 1: counter value written by the reset sweep; < 2^CTR_W.
- GHR_W, 5: history length; 1 ≤ GHR_W ≤ IDX_W.
- MODE, 1: 0 = bimodal (PC index only), 1 = gshare.

Ports:
- clk  in  1  clock, all state on rising edge.
- arst_n  in  1  reset, synchronous, active-low.
- ready  out  1  high once table clear complete.
- lookup_en  in  1  request a prediction.
- lookup_addr  in  ADDR_W  PC of fetched instruction.
- pred_valid  out  1  one-cycle pulse: prediction/pred_ghr valid.
- prediction  out  1  1 = predict taken.
- pred_ghr  out  GHR_W  GHR value used to form this prediction's index.
- upd_en  in  1  train one entry.
- upd_addr  in  ADDR_W  PC of resolved branch.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  resolved outcome differed from prediction.
- upd_ghr  in  GHR_W  pred_ghr returned with the branch.

## Operation
- Index: idx = addr[INDEX_SHIFT +: IDX_W] ^ (MODE ? zero-extended history : 0). Lookup uses the current GHR. Update uses upd_ghr, so training hits the entry that predicted.
- Prediction = MSB of the indexed counter.
- Training on upd_en: if upd_taken, counter +1, saturating at 2^CTR_W−1. Else counter −1, saturating at 0. No wrap-around under any input.
- FSM states are INIT and RUN.
  - Reset: state←INIT, sweep pointer←0, ghr←0, ready←0, pred_valid←0, prediction←0, pred_ghr←0.
  - INIT: write INIT_CTR to entry[ptr], ptr+1. At ptr = ENTRIES−1, move to RUN.
  - RUN: ready = 1. The FSM never returns to INIT except by reset.
- In INIT, lookup_en and upd_en are ignored: no pred_valid, no table or GHR change.
- GHR (RUN):
  - lookup_en alone: ghr ← {ghr[GHR_W−2:0], predicted bit}. This is a speculative update.
  - upd_en with upd_mispredict: ghr ← {upd_ghr[GHR_W−2:0], upd_taken}. This recovery overrides a same-cycle lookup shift.
  - upd_en without mispredict: GHR unchanged.
- GHR is maintained in MODE 0 but does not affect the index.

## Timing
- Prediction latency is 1 cycle. lookup_en at edge N gives pred_valid = 1 and prediction/pred_ghr valid after edge N+1, for one cycle.
  - Outputs hold their value when pred_valid = 0.
  - Back-to-back lookups give one prediction per cycle.
- An update is written at the edge after upd_en is sampled. A lookup in the same cycle to the same index returns the pre-update counter (read-before-write, no bypass).
- ready rises after exactly ENTRIES clock cycles in INIT following reset release.
- Reset asserted mid-sweep or mid-run: at the next edge, everything returns to the reset values above and the sweep restarts from entry 0.
- There is one update port. Back-to-back updates to the same entry accumulate, one step per cycle.

## Structure
- Shared package bp_pkg holds:
  - the FSM state enum (INIT, RUN);
  - MODE constants (BP_MODE_BIMODAL = 0, BP_MODE_GSHARE = 1);
  - the index-hash function.
- Sub-module bp_sat_counter: combinational next-value unit with CTR_W parameter, inputs cur/inc, output nxt, saturating both ends. It is reused by later predictors.
- The table is a single register array written by one port: sweep in INIT, training in RUN.

## Test plan
All scenarios use defaults unless stated.

1. Reset then idle: ready = 0 for 32 cycles, then 1. Every lookup of addr 0..124 step 4 predicts 0 (INIT_CTR = 1).
2. Saturation (MODE=0), addr 0x10:
   - 3× upd taken → counter 3, prediction 1. A 4th taken keeps it at 3.
   - Then 4× not-taken → 0, and a 5th keeps it at 0, prediction 0.
3. Gshare aliasing: two lookups of 0x20, each predicting 0, leave GHR = 5'b00000.
   - Upd addr 0x20, taken, upd_ghr = 5'b00011 → lookup 0x20 with GHR = 5'b00011 indexes entry 8^3 = 11 and predicts 1 after one more taken.
   - A lookup with GHR = 0 (entry 8) still predicts 0.
4. Mispredict recovery: GHR = 5'b10110; same cycle lookup_en = 1 and upd mispredict with upd_ghr = 5'b01001, upd_taken = 1 → GHR = 5'b10011 next cycle.
5. Same-cycle conflict: entry at counter 1; lookup and taken update of the same addr → prediction 0. The next lookup predicts 1.
6. Reset mid-sweep at cycle 10: ready stays 0, and ready rises 32 cycles after release. Lookups and updates issued during the sweep produce no pred_valid and no state change.
